// File: rtl/psk_track_ctl_if.sv
// -----------------------------------------------------------------------------
// psk_track_ctl_if
//
// Purpose:
//   Window/match-vector link between the code-phase tracking controller and
//   the PSK correlator dispatcher.
//
// Signals:
//   win_stb   controller -> dispatcher  one-cycle pulse ending a window
//   taps      dispatcher -> controller  OR-accumulated 8-tap match vector
//   taps_vld  dispatcher -> controller  one-cycle qualifier for taps
//
// Handshake:
//   win_stb is a request and taps_vld is its single-cycle answer; there is no
//   ready/backpressure. taps is only meaningful in a cycle where taps_vld=1.
//   The first taps_vld after a win_stb is taken as the answer for that
//   window. Later pulses are ignored until the next win_stb. A taps_vld in
//   the same cycle as win_stb answers the previous window. A window with no
//   answer before the next win_stb is treated as a miss.
// -----------------------------------------------------------------------------
interface psk_track_ctl_if;
   logic [7:0] taps;
   logic       taps_vld;
   logic       win_stb;

   // Dispatcher side
   modport master (
      output taps,
      output taps_vld,
      input  win_stb
   );

   // Tracking controller side
   modport slave (
      input  taps,
      input  taps_vld,
      output win_stb
   );
endinterface

// File: rtl/psk_track_ctl.sv
// -----------------------------------------------------------------------------
// psk_track_ctl
//
// Purpose:
//   Code-phase tracking controller for the PSK correlator dispatcher.
//   - Slices time into WIN_LEN-cycle correlation windows and pulses win_stb at
//     the end of each one.
//   - Collects the dispatcher's 8-tap match vector for that window.
//   - Steps the 16-position code phase: a coarse +2 sweep while searching and
//     a +/-1 early/late correction while tracking.
//   - Declares lock and drops it again.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   run enable; low forces IDLE on the next edge
//   disp       if   slave side of psk_track_ctl_if (taps, taps_vld, win_stb)
//   phase      out  current code-phase index, mod 16
//   phase_stb  out  one-cycle pulse when phase changes
//   phase_dir  out  direction of the last step (1 advance, 0 retard)
//   locked     out  high in LOCK
//   state      out  00 IDLE, 01 SEARCH, 10 TRACK, 11 LOCK
//   timeout    out  sticky: a window ended with its taps still pending
//
// Pipeline:
//   Stage 1, the window stage, is registered on the edge that samples
//   taps_vld or the overdue win_stb. It turns the dispatcher traffic into a
//   single window outcome event (evt_vld_q/evt_taps_q).
//   Stage 2, the FSM stage, applies that event on the following edge. Phase,
//   state, locked and phase_stb therefore move one edge after the sampling
//   edge.
// -----------------------------------------------------------------------------
module psk_track_ctl #(
   parameter int WIN_LEN  = 256,
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   psk_track_ctl_if.slave        disp,
   output logic [3:0]            phase,
   output logic                  phase_stb,
   output logic                  phase_dir,
   output logic                  locked,
   output logic [1:0]            state,
   output logic                  timeout
);

   localparam int                WCNT_W   = $clog2(WIN_LEN);
   localparam logic [WCNT_W-1:0] WCNT_TOP = WCNT_W'(WIN_LEN - 1);
   localparam logic [3:0]        LOCK_TH  = 4'(LOCK_CNT);
   localparam logic [3:0]        LOSS_TH  = 4'(LOSS_CNT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_SEARCH = 2'b01,
      S_TRACK  = 2'b10,
      S_LOCK   = 2'b11
   } state_t;

   state_t state_q, state_nxt;

   // ---------------------------------------------------------------------------
   // Window stage
   // ---------------------------------------------------------------------------
   logic [WCNT_W-1:0] wcnt_q, wcnt_nxt;
   logic              win_stb_q;
   logic              pending_q;
   logic              timeout_q;
   logic              evt_vld_q;
   logic [7:0]        evt_taps_q;
   logic              run;
   logic              consume;
   logic              overdue;

   // The window machinery only runs once the FSM has left IDLE. The cycle
   // that leaves IDLE holds wcnt at 0. The first win_stb therefore lands
   // WIN_LEN cycles after the first en=1 cycle.
   assign run = en && (state_q != S_IDLE);

   // A taps_vld that coincides with win_stb answers the old window. For that
   // reason an overdue window is only declared when no answer arrives in the
   // strobe cycle.
   assign consume = run && disp.taps_vld && pending_q;
   assign overdue = run && win_stb_q && pending_q && !disp.taps_vld;

   always_comb begin
      wcnt_nxt = '0;
      if (run) begin
         wcnt_nxt = (wcnt_q == WCNT_TOP) ? '0 : wcnt_q + WCNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q     <= '0;
         win_stb_q  <= 1'b0;
         pending_q  <= 1'b0;
         timeout_q  <= 1'b0;
         evt_vld_q  <= 1'b0;
         evt_taps_q <= 8'h00;
      end else begin
         wcnt_q     <= wcnt_nxt;
         // Registered look-ahead: high exactly while wcnt == WIN_LEN-1.
         win_stb_q  <= run && (wcnt_nxt == WCNT_TOP);
         evt_vld_q  <= consume || overdue;
         // An overdue window is judged as all-zero taps, i.e. a plain miss.
         evt_taps_q <= consume ? disp.taps : 8'h00;

         if (!run) begin
            pending_q <= 1'b0;
         end else if (win_stb_q) begin
            pending_q <= 1'b1;
         end else if (consume) begin
            pending_q <= 1'b0;
         end

         if (!en) begin
            timeout_q <= 1'b0;
         end else if (overdue) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign disp.win_stb = win_stb_q;

   // ---------------------------------------------------------------------------
   // Window outcome classification
   // ---------------------------------------------------------------------------
   logic prompt, early, late, nonzero;

   assign prompt  = |evt_taps_q[4:3];
   assign early   = |evt_taps_q[2:0];
   assign late    = |evt_taps_q[7:5];
   assign nonzero = |evt_taps_q;

   logic [3:0] hit_q, miss_q;
   logic [3:0] hit_inc, miss_inc;

   assign hit_inc  = (hit_q  == 4'hF) ? hit_q  : hit_q  + 4'd1;
   assign miss_inc = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state_q;
      if (!en) begin
         state_nxt = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_nxt = S_SEARCH;
            end
            S_SEARCH: begin
               if (evt_vld_q && nonzero) begin
                  state_nxt = S_TRACK;
               end
            end
            S_TRACK, S_LOCK: begin
               if (evt_vld_q) begin
                  if (prompt) begin
                     if ((state_q == S_TRACK) && (hit_inc >= LOCK_TH)) begin
                        state_nxt = S_LOCK;
                     end
                  end else if (miss_inc >= LOSS_TH) begin
                     state_nxt = S_SEARCH;
                  end
               end
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: output / datapath next values
   // ---------------------------------------------------------------------------
   logic [3:0] phase_q, phase_nxt;
   logic       dir_q, dir_nxt;
   logic       pstb_q, pstb_nxt;
   logic       locked_q;
   logic [3:0] hit_nxt, miss_nxt;

   always_comb begin
      phase_nxt = phase_q;
      dir_nxt   = dir_q;
      pstb_nxt  = 1'b0;
      hit_nxt   = hit_q;
      miss_nxt  = miss_q;

      if (!en) begin
         // Phase and last direction are kept across a disable.
         hit_nxt  = 4'd0;
         miss_nxt = 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               hit_nxt  = 4'd0;
               miss_nxt = 4'd0;
            end
            S_SEARCH: begin
               if (evt_vld_q) begin
                  if (nonzero) begin
                     hit_nxt  = 4'd0;
                     miss_nxt = 4'd0;
                  end else begin
                     // Coarse sweep; 4-bit arithmetic gives the mod-16 wrap.
                     phase_nxt = phase_q + 4'd2;
                     dir_nxt   = 1'b1;
                     pstb_nxt  = 1'b1;
                  end
               end
            end
            S_TRACK, S_LOCK: begin
               if (evt_vld_q) begin
                  if (prompt) begin
                     hit_nxt  = hit_inc;
                     miss_nxt = 4'd0;
                  end else begin
                     // Any non-prompt outcome counts toward loss, even one
                     // that also produces an early/late correction.
                     hit_nxt  = 4'd0;
                     miss_nxt = miss_inc;
                     if (early && !late) begin
                        phase_nxt = phase_q - 4'd1;
                        dir_nxt   = 1'b0;
                        pstb_nxt  = 1'b1;
                     end else if (late && !early) begin
                        phase_nxt = phase_q + 4'd1;
                        dir_nxt   = 1'b1;
                        pstb_nxt  = 1'b1;
                     end
                     // Falling back to SEARCH restarts both counters. The
                     // sweep carries on from the retained phase.
                     if (miss_inc >= LOSS_TH) begin
                        hit_nxt  = 4'd0;
                        miss_nxt = 4'd0;
                     end
                  end
               end
            end
            default: begin
               hit_nxt  = 4'd0;
               miss_nxt = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= 4'd0;
         dir_q    <= 1'b0;
         pstb_q   <= 1'b0;
         hit_q    <= 4'd0;
         miss_q   <= 4'd0;
         locked_q <= 1'b0;
      end else begin
         phase_q  <= phase_nxt;
         dir_q    <= dir_nxt;
         pstb_q   <= pstb_nxt;
         hit_q    <= hit_nxt;
         miss_q   <= miss_nxt;
         locked_q <= (state_nxt == S_LOCK);
      end
   end

   assign phase     = phase_q;
   assign phase_stb = pstb_q;
   assign phase_dir = dir_q;
   assign locked    = locked_q;
   assign state     = state_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_psk_track_ctl.sv
// -----------------------------------------------------------------------------
// tb_psk_track_ctl
//
// Directed bench for psk_track_ctl (WIN_LEN=256, LOCK_CNT=4, LOSS_CNT=8).
// Hand-written sequences cover the following:
//   - reset
//   - window timing and timeouts
//   - disable/re-enable
//   - simultaneous win_stb/taps_vld
//   - asynchronous reset
// A table of per-window answers covers the tracking, lock, loss and phase
// wrap behaviour. Inputs change on the falling edge and outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_psk_track_ctl;

   localparam int WIN_LEN = 256;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] phase;
   logic       phase_stb;
   logic       phase_dir;
   logic       locked;
   logic [1:0] state;
   logic       timeout;

   psk_track_ctl_if bus ();

   psk_track_ctl #(
      .WIN_LEN  (WIN_LEN),
      .LOCK_CNT (4),
      .LOSS_CNT (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .disp      (bus),
      .phase     (phase),
      .phase_stb (phase_stb),
      .phase_dir (phase_dir),
      .locked    (locked),
      .state     (state),
      .timeout   (timeout)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=still_running required=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [8:0] exp_q[$];   // {phase, state, locked, phase_dir, phase_stb}

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] taps;
      int         dly;
      logic [3:0] phase;
      logic [1:0] state;
      logic       locked;
      logic       dir;
      logic       stb;
   } vec_t;

   vec_t vec_q[$];

   task automatic add(input logic [7:0] t, input int d, input logic [3:0] p,
                      input logic [1:0] s, input logic l, input logic dr, input logic sb);
      vec_t v;
      v.taps = t; v.dly = d; v.phase = p; v.state = s;
      v.locked = l; v.dir = dr; v.stb = sb;
      vec_q.push_back(v);
   endtask

   // ---------------- driver tasks ----------------
   // Returns at the falling edge inside the next win_stb cycle.
   // n = falling edges waited.
   task automatic wait_win(output int n);
      bit found;
      found = 1'b0;
      n = 0;
      while (!found && n < WIN_LEN + 8) begin
         @(negedge clk);
         n++;
         found = bus.win_stb;
      end
      if (!found) begin
         checks++;
         failures++;
         $display("FAIL win_stb_wait actual=none required=pulse_within_%0d_cycles", WIN_LEN + 8);
      end
   endtask

   task automatic pulse_taps(input logic [7:0] t);
      bus.taps     = t;
      bus.taps_vld = 1'b1;
      @(negedge clk);
      bus.taps     = 8'h00;
      bus.taps_vld = 1'b0;
   endtask

   // Answer the window opened by the next win_stb, then check outputs on the
   // edge after the sampling edge.
   task automatic apply_vec(input vec_t v, input int idx);
      int n;
      logic [8:0] got;
      logic [8:0] exp;
      wait_win(n);
      repeat (v.dly) @(negedge clk);
      pulse_taps(v.taps);
      @(negedge clk);
      got = {phase, state, locked, phase_dir, phase_stb};
      exp = exp_q.pop_front();
      chk($sformatf("vec%0d_taps%02h", idx, v.taps), 32'(got), 32'(exp));
      if (v.stb) begin
         @(negedge clk);
         chk($sformatf("vec%0d_stb_one_cycle", idx), 32'(phase_stb), 32'd0);
      end
   endtask

   // ---------------- test ----------------
   initial begin
      int n;
      int stb_seen;

      rst_n        = 1'b0;
      en           = 1'b0;
      bus.taps     = 8'h00;
      bus.taps_vld = 1'b0;

      // Table: {taps, delay, phase, state, locked, dir, stb}.
      // Starts in TRACK at phase 4 after the hand-written SEARCH sequence.
      add(8'h20, 2, 4'd5,  2'd2, 0, 1, 1);   // late only -> +1
      add(8'h01, 3, 4'd4,  2'd2, 0, 0, 1);   // early only -> -1
      add(8'h18, 1, 4'd4,  2'd2, 0, 0, 0);   // prompt 1
      add(8'h18, 5, 4'd4,  2'd2, 0, 0, 0);   // prompt 2
      add(8'h18, 1, 4'd4,  2'd2, 0, 0, 0);   // prompt 3
      add(8'h18, 7, 4'd4,  2'd3, 1, 0, 0);   // prompt 4 -> LOCK
      add(8'h80, 2, 4'd5,  2'd3, 1, 1, 1);   // miss 1, late step in LOCK
      add(8'hA5, 1, 4'd5,  2'd3, 1, 1, 0);   // miss 2, early+late hold
      for (int i = 0; i < 5; i++) add(8'h00, 1 + i, 4'd5, 2'd3, 1, 1, 0);  // misses 3..7
      add(8'h08, 2, 4'd5,  2'd3, 1, 1, 0);   // prompt clears miss count
      for (int i = 0; i < 7; i++) add(8'h00, 2, 4'd5, 2'd3, 1, 1, 0);      // misses 1..7
      add(8'h00, 3, 4'd5,  2'd1, 0, 1, 0);   // miss 8 -> SEARCH
      add(8'h00, 1, 4'd7,  2'd1, 0, 1, 1);   // sweep from retained phase
      add(8'h00, 1, 4'd9,  2'd1, 0, 1, 1);
      add(8'h00, 1, 4'd11, 2'd1, 0, 1, 1);
      add(8'h00, 1, 4'd13, 2'd1, 0, 1, 1);
      add(8'h00, 1, 4'd15, 2'd1, 0, 1, 1);
      add(8'h40, 4, 4'd15, 2'd2, 0, 1, 0);   // SEARCH hit -> TRACK, no step
      add(8'h40, 1, 4'd0,  2'd2, 0, 1, 1);   // 15+1 -> 0, miss 1
      add(8'h02, 1, 4'd15, 2'd2, 0, 0, 1);   // 0-1 -> 15, miss 2
      add(8'h04, 1, 4'd14, 2'd2, 0, 0, 1);   // miss 3
      for (int i = 0; i < 4; i++) add(8'h00, 1, 4'd14, 2'd2, 0, 0, 0);   // misses 4..7
      add(8'h00, 1, 4'd14, 2'd1, 0, 0, 0);   // miss 8 -> SEARCH
      add(8'h00, 1, 4'd0,  2'd1, 0, 1, 1);   // 14+2 -> 0
      add(8'h10, 2, 4'd0,  2'd2, 0, 1, 0);   // -> TRACK
      add(8'h20, 2, 4'd1,  2'd2, 0, 1, 1);   // late -> 1
      add(8'h08, 1, 4'd1,  2'd2, 0, 1, 0);
      add(8'h08, 1, 4'd1,  2'd2, 0, 1, 0);
      add(8'h08, 1, 4'd1,  2'd2, 0, 1, 0);
      add(8'h08, 1, 4'd1,  2'd3, 1, 1, 0);   // -> LOCK

      // Reset values
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_win_stb",   32'(bus.win_stb), 32'd0);
      chk("rst_phase",     32'(phase),       32'd0);
      chk("rst_phase_stb", 32'(phase_stb),   32'd0);
      chk("rst_phase_dir", 32'(phase_dir),   32'd0);
      chk("rst_locked",    32'(locked),      32'd0);
      chk("rst_state",     32'(state),       32'd0);
      chk("rst_timeout",   32'(timeout),     32'd0);

      // First window: WIN_LEN cycles after the first en=1 cycle
      en = 1'b1;
      wait_win(n);
      chk("first_win_gap", 32'(n), 32'd256);
      chk("search_state",  32'(state), 32'd1);
      chk("first_win_no_timeout", 32'(timeout), 32'd0);

      // Second window ends with taps still pending
      wait_win(n);
      chk("second_win_gap", 32'(n), 32'd256);
      chk("timeout_not_yet", 32'(timeout), 32'd0);
      @(negedge clk);
      chk("timeout_set",     32'(timeout), 32'd1);
      chk("win_stb_one_cyc", 32'(bus.win_stb), 32'd0);
      chk("phase_before_step", 32'(phase), 32'd0);
      @(negedge clk);
      chk("sweep_phase2", 32'({phase, phase_dir, phase_stb}), 32'({4'd2, 1'b1, 1'b1}));
      @(negedge clk);
      chk("sweep_stb_low", 32'(phase_stb), 32'd0);

      // Third window also overdue -> 4; then answer late-only in SEARCH
      wait_win(n);
      chk("third_win_gap", 32'(n), 32'd253);
      @(negedge clk);
      @(negedge clk);
      chk("sweep_phase4", 32'({phase, phase_stb}), 32'({4'd4, 1'b1}));
      pulse_taps(8'h20);
      @(negedge clk);
      chk("search_to_track", 32'({phase, state, phase_stb}), 32'({4'd4, 2'd2, 1'b0}));
      chk("timeout_sticky",  32'(timeout), 32'd1);

      // Table-driven windows
      for (int i = 0; i < vec_q.size(); i++) begin
         exp_q.push_back({vec_q[i].phase, vec_q[i].state, vec_q[i].locked,
                          vec_q[i].dir, vec_q[i].stb});
         apply_vec(vec_q[i], i);
      end

      // Drop en mid-window while pending in LOCK
      wait_win(n);
      repeat (5) @(negedge clk);
      chk("pre_drop_locked", 32'(locked), 32'd1);
      en = 1'b0;
      @(negedge clk);
      chk("drop_state",   32'(state),       32'd0);
      chk("drop_locked",  32'(locked),      32'd0);
      chk("drop_timeout", 32'(timeout),     32'd0);
      chk("drop_phase",   32'(phase),       32'd1);
      chk("drop_strobes", 32'({bus.win_stb, phase_stb}), 32'd0);
      stb_seen = 0;
      repeat (300) begin
         @(negedge clk);
         if (bus.win_stb || phase_stb) stb_seen++;
      end
      chk("idle_no_strobes", 32'(stb_seen), 32'd0);

      // Re-enable; taps_vld coincident with win_stb answers the old window
      en = 1'b1;
      wait_win(n);
      chk("reen_win_gap", 32'(n), 32'd256);
      wait_win(n);
      pulse_taps(8'h08);
      chk("coincident_no_timeout", 32'(timeout), 32'd0);
      @(negedge clk);
      chk("coincident_track", 32'({phase, state, timeout}), 32'({4'd1, 2'd2, 1'b0}));
      // Pending was re-set by that strobe, so the next window is overdue
      wait_win(n);
      @(negedge clk);
      chk("repend_timeout", 32'(timeout), 32'd1);

      // Asynchronous reset mid-cycle
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_phase",   32'(phase),       32'd0);
      chk("arst_dir",     32'(phase_dir),   32'd0);
      chk("arst_state",   32'(state),       32'd0);
      chk("arst_locked",  32'(locked),      32'd0);
      chk("arst_timeout", 32'(timeout),     32'd0);
      chk("arst_strobes", 32'({bus.win_stb, phase_stb}), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/psk_track_ctl.md
# psk_track_ctl

Code-phase tracking controller for the PSK correlator dispatcher. It divides time into fixed correlation windows and pulses a window strobe to the dispatcher at the end of each one. It then takes back the 8-tap match vector and steps the 16-position base-code phase. The step is a coarse sweep while searching and a fine early/late correction while tracking. It also declares and drops lock.

## Interface
- WIN_LEN, 256: correlation window length in clk cycles (≥ 4).
- LOCK_CNT, 4: consecutive prompt hits in TRACK needed to enter LOCK (1..15).
- LOSS_CNT, 8: consecutive misses that drop TRACK/LOCK back to SEARCH (1..15).

- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low forces IDLE synchronously.
- taps  in  8  OR-accumulated correlator match vector for the last window; bit j = tap j.
- taps_vld  in  1  one-cycle qualifier for taps.
- win_stb  out  1  one-cycle pulse ending a window; dispatcher latches and clears on it.
- phase  out  4  current code-phase index, mod 16.
- phase_stb  out  1  one-cycle pulse when phase changes.
- phase_dir  out  1  direction of the last step: 1 = advance, 0 = retard.
- locked  out  1  high in LOCK state.
- state  out  2  00 IDLE, 01 SEARCH, 10 TRACK, 11 LOCK.
- timeout  out  1  sticky: a window ended with taps still pending; cleared on reset or when en is low.

## Operation
- Window counter wcnt runs 0..WIN_LEN-1 while en=1 and wraps at the top. win_stb=1 in the cycle where wcnt==WIN_LEN-1.
- win_stb sets a pending flag. The first taps_vld while pending is consumed and clears pending. taps_vld while not pending is ignored.
- If win_stb fires while pending is still set:
  - set timeout;
  - evaluate the overdue window as a miss;
  - pending stays set for the new window.
- Classification of consumed taps:
  - prompt = taps[4:3] nonzero;
  - early = taps[2:0] nonzero;
  - late = taps[7:5] nonzero;
  - miss = taps==0 or timeout-evaluated.
- IDLE: en rising moves the FSM to SEARCH, with wcnt=0 and both counters cleared.
- SEARCH:
  - miss: phase += 2, with phase_dir=1 and phase_stb.
  - any nonzero taps: go to TRACK with hit_cnt=0, miss_cnt=0, and no phase step.
- TRACK and LOCK, on each window outcome:
  - prompt: hit_cnt += 1 (saturating) and miss_cnt = 0. In TRACK, if hit_cnt reaches LOCK_CNT, go to LOCK.
  - not prompt, early only: phase -= 1, phase_dir=0.
  - not prompt, late only: phase += 1, phase_dir=1.
  - not prompt, both early and late: hold.
  - all non-prompt outcomes: hit_cnt = 0 and miss_cnt += 1. A nonzero non-prompt result counts as a miss for loss purposes.
  - miss_cnt reaching LOSS_CNT: go to SEARCH and clear both counters. Phase is retained and the search sweep resumes from it.
- Phase arithmetic is 4-bit modulo 16: 15+1→0, 14+2→0, 0−1→15.
- en=0 during any state:
  - next cycle: state=IDLE, wcnt=0, pending=0, counters=0, locked=0, timeout=0;
  - phase retains its value;
  - win_stb and phase_stb are not asserted.

## Timing
- Reset values: win_stb=0, phase=0, phase_stb=0, phase_dir=0, locked=0, state=IDLE, timeout=0. Internally wcnt=0, pending=0, counters=0.
- First win_stb occurs WIN_LEN cycles after the first en=1 cycle, then every WIN_LEN cycles.
- Decision latency: with taps_vld sampled at edge k, phase, state, locked and phase_stb update at edge k+1. phase_stb stays high for exactly that cycle.
- Timeout decisions update at the edge after the overdue win_stb.
- win_stb and taps_vld in the same cycle:
  - taps resolve the old pending window;
  - pending is then re-set for the new window;
  - no timeout is raised.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset then en=1, taps never valid → win_stb every 256 cycles; timeout set at the second win_stb; phase steps 0→2→4… with phase_stb each window; state=SEARCH.
- SEARCH, taps=8'h20 answered 3 cycles after win_stb → state=TRACK, phase unchanged. A following taps=8'h20 → phase+1, phase_dir=1. A following taps=8'h01 → phase−1, phase_dir=0.
- TRACK with four consecutive taps=8'h18 → locked=1 and state=LOCK on the edge after the fourth taps_vld.
- LOCK, then eight consecutive taps=8'h00 → state=SEARCH and locked=0 after the eighth. Seven misses followed by one 8'h08 → LOCK retained and miss_cnt cleared.
- Phase wrap: set phase to 15 and apply late-only taps → phase=0. Set phase to 14 and apply a SEARCH miss → phase=0.
- Drop en mid-window while pending in LOCK → next cycle IDLE with all flags clear and phase held. Assert rst_n=0 asynchronously mid-cycle → all outputs reset immediately.
